// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage constants: payload widths, FSM encoding and bubble values.
package mem_stage_pkg;

  localparam int unsigned WbW    = 4;
  localparam int unsigned AluW   = 64;
  localparam int unsigned DestW  = 5;
  localparam int unsigned FloatW = 2;
  localparam int unsigned AddrW  = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  localparam logic [WbW-1:0] BubbleWb   = '0;
  localparam logic           BubbleCtrl = 1'b0;

endpackage

// File: rtl/mem_stage_wait_timer.sv
// Counts data-memory wait cycles; expired marks the last cycle an ack may still arrive.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count   = r_count;
  assign expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU ops through, runs loads/stores over a req/ack port with timeout.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WbW-1:0]    wb_in,
  input  logic [AluW-1:0]   alu_res_in,
  input  logic [DestW-1:0]  dest_in,
  input  logic [FloatW-1:0] float_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [AddrW-1:0]  dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [WbW-1:0]    wb_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [AluW-1:0]   alu_res_out,
  output logic [DestW-1:0]  dest_out,
  output logic [FloatW-1:0] float_out,
  output logic              alu_mem_read_out,
  output logic              alu_RegWrite_out,
  output logic              stall,
  output logic              mem_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  mem_state_e        r_state;
  logic [WbW-1:0]    r_wb;
  logic [AluW-1:0]   r_alu;
  logic [DestW-1:0]  r_dest;
  logic [FloatW-1:0] r_float;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_we;
  logic              r_mem_read;
  logic              r_reg_write;
  logic              r_timed_out;

  logic              w_mem_op;
  logic              w_start;
  logic              w_wait;
  logic              w_expired;
  logic [CntW-1:0]   w_unused_wait_cnt;

  assign w_mem_op = mem_read_in | mem_write_in;
  assign w_start  = (r_state == StIdle) && w_mem_op;
  assign w_wait   = (r_state == StBusy) && !dmem_ack;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CntW)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_start),
    .enable (w_wait),
    .count  (w_unused_wait_cnt),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wb        <= '0;
      r_alu       <= '0;
      r_dest      <= '0;
      r_float     <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_we        <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_mem_op) begin
            r_wb        <= wb_in;
            r_alu       <= alu_res_in;
            r_dest      <= dest_in;
            r_float     <= float_in;
            r_wdata     <= store_data_in;
            // Read+write together is a store.
            r_we        <= mem_write_in;
            r_mem_read  <= mem_read_in & ~mem_write_in;
            r_reg_write <= reg_write_in;
            r_rdata     <= '0;
            r_timed_out <= 1'b0;
            r_state     <= StBusy;
          end
        end
        StBusy: begin
          // An ack on the final wait cycle beats the timeout.
          if (dmem_ack) begin
            r_rdata <= r_we ? '0 : dmem_rdata;
            r_state <= StDone;
          end else if (w_expired) begin
            r_timed_out <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dmem_we    = r_we;
  assign dmem_addr  = r_alu[AddrW-1:0];
  assign dmem_wdata = r_wdata;

  always_comb begin
    stall            = 1'b0;
    dmem_req         = 1'b0;
    mem_err          = 1'b0;
    wb_out           = BubbleWb;
    mem_data_out     = '0;
    alu_res_out      = '0;
    dest_out         = '0;
    float_out        = '0;
    alu_mem_read_out = BubbleCtrl;
    alu_RegWrite_out = BubbleCtrl;
    if (!rst) begin
      unique case (r_state)
        StIdle: begin
          if (w_mem_op) begin
            stall = 1'b1;
          end else begin
            wb_out           = wb_in;
            alu_res_out      = alu_res_in;
            dest_out         = dest_in;
            float_out        = float_in;
            alu_mem_read_out = mem_read_in;
            alu_RegWrite_out = reg_write_in;
          end
        end
        StBusy: begin
          stall    = 1'b1;
          dmem_req = 1'b1;
          mem_err  = w_wait && w_expired;
        end
        StDone: begin
          wb_out           = r_wb;
          mem_data_out     = r_rdata;
          alu_res_out      = r_alu;
          dest_out         = r_dest;
          float_out        = r_float;
          alu_mem_read_out = r_mem_read;
          alu_RegWrite_out = r_reg_write & ~r_timed_out;
        end
        default: ;
      endcase
    end
  end

endmodule
